// File: rtl/counter_sweep_ctrl.sv
// Triangle sweep controller: drives an external up/down counter 0..peak..0 for a
// number of repetitions. Define COUNTER_CHECK_EN to add a shadow count checker.
module counter_sweep_ctrl #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [DATA_W-1:0] peak,
  input  logic [3:0]        reps,
  input  logic [DATA_W-1:0] cnt_count,
  output logic              cnt_rst_n,
  output logic              cnt_down,
  output logic              busy,
  output logic              done,
  output logic [3:0]        rep_left,
  output logic              err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_UP   = 2'd1,
    S_DOWN = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] peak_q, peak_d;
  // One extra bit so that reps=0 can be held as a true count of 16.
  logic [4:0]        rep_q, rep_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              chk_err;

`ifdef COUNTER_CHECK_EN
  logic [DATA_W-1:0] exp_q, exp_d;
`endif

  // Counter commands are combinational so the turn-around at peak and zero
  // happens in the same cycle the apex value is observed.
  always_comb begin
    cnt_rst_n = 1'b0;
    cnt_down  = 1'b0;
    if (!abort) begin
      case (state_q)
        S_UP: begin
          cnt_rst_n = 1'b1;
          cnt_down  = (cnt_count == peak_q);
        end
        S_DOWN: begin
          if (cnt_count != '0) begin
            cnt_rst_n = 1'b1;
            cnt_down  = 1'b1;
          end else if (rep_q > 5'd1) begin
            cnt_rst_n = 1'b1;
          end
        end
        default: begin
          cnt_rst_n = 1'b0;
          cnt_down  = 1'b0;
        end
      endcase
    end
  end

`ifdef COUNTER_CHECK_EN
  always_comb begin
    if (!cnt_rst_n)
      exp_d = '0;
    else if (cnt_down)
      exp_d = exp_q - 1'b1;
    else
      exp_d = exp_q + 1'b1;
    chk_err = ((state_q == S_UP) || (state_q == S_DOWN)) && (cnt_count != exp_q);
  end
`else
  assign chk_err = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    peak_d  = peak_q;
    rep_d   = rep_q;
    err_d   = err_q;
    if (abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            if (peak != '0) begin
              state_d = S_UP;
              peak_d  = peak;
              rep_d   = (reps == 4'd0) ? 5'd16 : {1'b0, reps};
              err_d   = 1'b0;
            end else begin
              err_d   = 1'b1;
            end
          end
        end
        S_UP: begin
          if (cnt_count == peak_q)
            state_d = S_DOWN;
        end
        S_DOWN: begin
          if (cnt_count == '0) begin
            if (rep_q > 5'd1) begin
              rep_d   = rep_q - 5'd1;
              state_d = S_UP;
            end else begin
              state_d = S_DONE;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
    if (chk_err)
      err_d = 1'b1;
    busy_d = (state_d == S_UP) || (state_d == S_DOWN);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      peak_q  <= '0;
      rep_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef COUNTER_CHECK_EN
      exp_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      peak_q  <= peak_d;
      rep_q   <= rep_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
`ifdef COUNTER_CHECK_EN
      exp_q   <= exp_d;
`endif
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;
  assign rep_left = rep_q[3:0];

endmodule

// File: tb/tb_counter_sweep_ctrl.sv
// Scoreboard bench for counter_sweep_ctrl with a behavioural up/down counter.
module tb_counter_sweep_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [7:0] peak = 8'd0;
  logic [3:0] reps = 4'd0;
  logic [7:0] cnt_count;
  logic       cnt_rst_n, cnt_down, busy, done, err;
  logic [3:0] rep_left;

  logic [7:0] cnt_model = 8'd0;
  logic [7:0] inj = 8'd0;
  bit         mon_en = 1'b1;

  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    logic       busy;
    logic       done;
    logic [7:0] cnt;
    logic [3:0] rep;
    logic       err;
  } exp_t;
  exp_t sb_q[$];

`ifdef COUNTER_CHECK_EN
  localparam logic CHK_ERR = 1'b1;
`else
  localparam logic CHK_ERR = 1'b0;
`endif

  counter_sweep_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .abort     (abort),
    .peak      (peak),
    .reps      (reps),
    .cnt_count (cnt_count),
    .cnt_rst_n (cnt_rst_n),
    .cnt_down  (cnt_down),
    .busy      (busy),
    .done      (done),
    .rep_left  (rep_left),
    .err       (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!cnt_rst_n)
      cnt_model <= 8'd0;
    else if (cnt_down)
      cnt_model <= cnt_model - 8'd1;
    else
      cnt_model <= cnt_model + 8'd1;
  end
  assign cnt_count = cnt_model + inj;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic push(input logic b, input logic d, input logic [7:0] c, input logic [3:0] r);
    exp_t e;
    e.busy = b; e.done = d; e.cnt = c; e.rep = r; e.err = 1'b0;
    sb_q.push_back(e);
  endtask

  // Expected trace of a full sweep: leading 0, then R triangles 1..P..0, then done.
  task automatic push_tri(input int p, input int r);
    int rr;
    rr = (r == 0) ? 16 : r;
    push(1'b1, 1'b0, 8'd0, 4'(rr));
    for (int k = 0; k < rr; k++) begin
      for (int v = 1; v <= p; v++) push(1'b1, 1'b0, 8'(v), 4'(rr - k));
      for (int v = p - 1; v >= 0; v--) push(1'b1, 1'b0, 8'(v), 4'(rr - k));
    end
    push(1'b0, 1'b1, 8'd0, 4'd1);
  endtask

  // Start at cycle 0; returns one tick into cycle 1 with peak/reps scrambled.
  task automatic do_start(input logic [7:0] p, input logic [3:0] r);
    @(posedge clk); #1;
    start = 1'b1; peak = p; reps = r;
    @(posedge clk); #1;
    start = 1'b0; peak = ~p; reps = ~r;
  endtask

  task automatic wait_done(input string name, input int limit);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < limit && !seen; k++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    chk({name, "_done_seen"}, 32'(seen), 32'd1);
    @(negedge clk);
    chk({name, "_done_1cyc"}, {busy, done}, 32'd0);
  endtask

  always @(negedge clk) begin
    if (mon_en && !rst && (busy || done)) begin
      if (sb_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL sb_unexpected: got busy=%0b done=%0b cnt=%0d with no entry expected", busy, done, cnt_count);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        n_chk++;
        if ({busy, done, cnt_count, rep_left, err} !== {e.busy, e.done, e.cnt, e.rep, e.err}) begin
          n_fail++;
          $display("FAIL sb_trace: got busy=%0b done=%0b cnt=%0d rep=%0d err=%0b expected busy=%0b done=%0b cnt=%0d rep=%0d err=%0b at %0t",
                   busy, done, cnt_count, rep_left, err, e.busy, e.done, e.cnt, e.rep, e.err, $time);
        end
      end
    end
  end

  initial begin
    #1_500_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] v18c [7]  = '{0, 1, 2, 3, 2, 1, 0};
    logic [7:0] v19c [13] = '{0, 1, 2, 1, 0, 1, 2, 1, 0, 1, 2, 1, 0};
    logic [3:0] v19r [13] = '{3, 3, 3, 3, 3, 2, 2, 2, 2, 1, 1, 1, 1};

    repeat (2) @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_err", err, 0);
    chk("reset_rep_left", rep_left, 0);
    chk("reset_cnt_rst_n", cnt_rst_n, 0);
    chk("reset_cnt_down", cnt_down, 0);
    rst = 1'b0;

    // peak=3, reps=1
    for (int i = 0; i < 7; i++) push(1'b1, 1'b0, v18c[i], 4'd1);
    push(1'b0, 1'b1, 8'd0, 4'd1);
    do_start(8'd3, 4'd1);
    wait_done("p3r1", 20);

    // peak=2, reps=3
    for (int i = 0; i < 13; i++) push(1'b1, 1'b0, v19c[i], v19r[i]);
    push(1'b0, 1'b1, 8'd0, 4'd1);
    do_start(8'd2, 4'd3);
    wait_done("p2r3", 30);

    // peak=0 request, then valid start clears err, start while busy ignored
    do_start(8'd0, 4'd2);
    @(negedge clk);
    chk("bad_req_err", err, 1);
    chk("bad_req_idle", busy, 0);
    push_tri(2, 1);
    do_start(8'd2, 4'd1);
    @(negedge clk);
    chk("start_clears_err", err, 0);
    @(posedge clk); #1;
    start = 1'b1; peak = 8'd7; reps = 4'd5;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done("busy_ign", 20);

    // abort at cycle 4 of peak=5
    for (int i = 0; i < 4; i++) push(1'b1, 1'b0, 8'(i), 4'd1);
    do_start(8'd5, 4'd1);
    repeat (3) begin @(posedge clk); #1; end
    abort = 1'b1;
    @(negedge clk);
    chk("abort_rst_n", cnt_rst_n, 0);
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk);
    chk("abort_idle", {busy, done}, 0);
    chk("abort_cnt0", cnt_count, 0);
    push_tri(1, 2);
    do_start(8'd1, 4'd2);
    wait_done("after_abort", 20);

    // peak=255, reps=0 (16 triangles): done at cycle 8162
    push_tri(255, 0);
    do_start(8'd255, 4'd0);
    wait_done("p255r16", 8300);

    chk("sb_drain", sb_q.size(), 0);

    // Off-by-one count injected in cycle 3
    mon_en = 1'b0;
    do_start(8'd6, 4'd1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    inj = 8'd1;
    @(posedge clk); #1;
    inj = 8'd0;
    @(negedge clk);
    chk("chk_err_next", err, 32'(CHK_ERR));
    wait_done("inject", 30);
    chk("chk_err_sticky", err, 32'(CHK_ERR));

    // Asynchronous reset mid-sweep, then first start after release
    do_start(8'd4, 4'd2);
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("async_rst_busy", busy, 0);
    chk("async_rst_rep", rep_left, 0);
    chk("async_rst_cmd", {cnt_rst_n, cnt_down}, 0);
    @(negedge clk);
    rst = 1'b0;
    do_start(8'd1, 4'd1);
    @(negedge clk);
    chk("post_rst_start", busy, 1);
    wait_done("post_rst", 20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
